// File: rtl/arbitrate_if.sv
// Stream bundle between N requesters, the arbiter and one downstream consumer.
// The arbiter takes the slave view. The environment (requesters plus sink) takes the master view.
interface arbitrate_if #(
   parameter int N = 2,
   parameter int W = 8
);
   localparam int IW = $clog2(N);

   logic [N-1:0]    s_stb;
   logic [N*W-1:0]  s_dat;
   logic [N-1:0]    s_rdy;
   logic            m_stb;
   logic [IW+W-1:0] m_dat;
   logic            m_rdy;

   modport master (
      output s_stb, s_dat, m_rdy,
      input  s_rdy, m_stb, m_dat
   );

   modport slave (
      input  s_stb, s_dat, m_rdy,
      output s_rdy, m_stb, m_dat
   );
endinterface

// File: rtl/arbitrate.sv
// N-to-1 stream arbiter with a registered {index, data} output stage.
// ARBITRATE_ROUND_ROBIN_EN selects circular priority from ptr_r; otherwise the lowest index wins.
module arbitrate #(
   parameter int W = 8,
   parameter int N = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   arbitrate_if.slave bus
);
   localparam int IW = $clog2(N);

   logic            acc_s;
   logic            any_s;
   logic [IW-1:0]   win_s;
   logic [N-1:0]    rdy_s;
   logic [W-1:0]    dat_s;
   logic            m_stb_r;
   logic [IW+W-1:0] m_dat_r;
`ifdef ARBITRATE_ROUND_ROBIN_EN
   logic [IW-1:0]   ptr_r;
   logic [IW-1:0]   ptr_nxt_s;
   int              idx_s;
`endif

   // Stage can take a word when empty or draining this cycle
   always_comb begin
      acc_s = !m_stb_r || bus.m_rdy;
   end

   // Winner search: circular from ptr_r, or fixed lowest-index priority
   always_comb begin
      any_s = 1'b0;
      win_s = '0;
`ifdef ARBITRATE_ROUND_ROBIN_EN
      idx_s = 0;
      for (int k = 0; k < N; k++) begin
         idx_s = int'(ptr_r) + k;
         // Wrap at N rather than at the power of two above it
         if (idx_s >= N) begin
            idx_s = idx_s - N;
         end else begin
            idx_s = idx_s;
         end
         if (!any_s && bus.s_stb[IW'(idx_s)]) begin
            any_s = 1'b1;
            win_s = IW'(idx_s);
         end else begin
            any_s = any_s;
         end
      end
`else
      for (int k = N - 1; k >= 0; k--) begin
         if (bus.s_stb[IW'(k)]) begin
            any_s = 1'b1;
            win_s = IW'(k);
         end else begin
            any_s = any_s;
         end
      end
`endif
   end

   // One-hot accept, gated by stage availability
   always_comb begin
      rdy_s = '0;
      if (acc_s && any_s) begin
         rdy_s[win_s] = 1'b1;
      end else begin
         rdy_s = '0;
      end
   end

   // Data mux; constant slice offsets keep the select free of multipliers
   always_comb begin
      dat_s = '0;
      for (int k = 0; k < N; k++) begin
         if (win_s == IW'(k)) begin
            dat_s = bus.s_dat[k*W +: W];
         end else begin
            dat_s = dat_s;
         end
      end
   end

`ifdef ARBITRATE_ROUND_ROBIN_EN
   // Pointer moves one past the winner, wrapping from N-1 to 0
   always_comb begin
      if (win_s == IW'(N - 1)) begin
         ptr_nxt_s = '0;
      end else begin
         ptr_nxt_s = win_s + IW'(1);
      end
   end
`endif

   // Output holding register and priority pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_stb_r <= 1'b0;
         m_dat_r <= '0;
`ifdef ARBITRATE_ROUND_ROBIN_EN
         ptr_r   <= '0;
`endif
      end else if (acc_s) begin
         if (any_s) begin
            m_stb_r <= 1'b1;
            m_dat_r <= {win_s, dat_s};
`ifdef ARBITRATE_ROUND_ROBIN_EN
            ptr_r   <= ptr_nxt_s;
`endif
         end else begin
            m_stb_r <= 1'b0;
         end
      end
   end

   assign bus.s_rdy = rdy_s;
   assign bus.m_stb = m_stb_r;
   assign bus.m_dat = m_dat_r;
endmodule
